// File: rtl/data_cache_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_controller_pkg
// Brief    : Geometry constants, FSM state type and a line-merge helper for
//            the direct-mapped write-back data cache.
// Revision : 1.0 - initial release
// ============================================================================
package data_cache_controller_pkg;

  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int NUM_LINES      = 8;
  localparam int OFFSET_W       = 2;
  localparam int INDEX_W        = 3;
  localparam int TAG_W          = 25;
  localparam int BLOCK_ADDR_W   = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_UPDATE    = 2'd3
  } cache_state_e;

  // Replace one word of a line, leaving the other words untouched.
  function automatic logic [LINE_W-1:0] merge_word(
    input logic [LINE_W-1:0]   line,
    input logic [OFFSET_W-1:0] offset,
    input logic [WORD_W-1:0]   word
  );
    logic [LINE_W-1:0] result;
    result = line;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if (offset == w[OFFSET_W-1:0]) begin
        result[w*WORD_W +: WORD_W] = word;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_controller_cache_line_store.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_store
// Brief    : Data/tag/valid/dirty arrays of the cache. One full-line write
//            port, combinational read port. Only valid/dirty are reset.
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_store
  import data_cache_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [LINE_W-1:0]  rd_data,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [LINE_W-1:0]  wr_data,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_dirty
);

  logic [LINE_W-1:0]    data_mem [NUM_LINES];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_bits;
  logic [NUM_LINES-1:0] dirty_bits;

  // Data and tag arrays need no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_index] <= wr_data;
      tag_mem[wr_index]  <= wr_tag;
    end
  end

  // Every line write leaves the line valid; dirty comes from the writer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_index] <= 1'b1;
      dirty_bits[wr_index] <= wr_dirty;
    end
  end

  assign rd_data  = data_mem[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_bits[rd_index];
  assign rd_dirty = dirty_bits[rd_index];

endmodule
`default_nettype wire

// File: rtl/data_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : data_cache_controller
// Brief    : 8-line direct-mapped, 4 words/line, write-back, write-allocate
//            data cache controller with block-level memory interface.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache_controller
  import data_cache_controller_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             address,
  input  logic [WORD_W-1:0]       writedata,
  output logic [WORD_W-1:0]       readdata,
  output logic                    busywait,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [BLOCK_ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0]       mem_writedata,
  input  logic [LINE_W-1:0]       mem_readdata,
  input  logic                    mem_busywait
);

  cache_state_e state, next_state;

  logic [OFFSET_W-1:0]     offset;
  logic [INDEX_W-1:0]      index;
  logic [TAG_W-1:0]        tag;
  logic                    request;
  logic                    hit;
  logic [INDEX_W-1:0]      store_index;
  logic [LINE_W-1:0]       line_data;
  logic [TAG_W-1:0]        line_tag;
  logic                    line_valid;
  logic                    line_dirty;
  logic                    wr_en;
  logic [INDEX_W-1:0]      wr_index;
  logic [LINE_W-1:0]       wr_data;
  logic [TAG_W-1:0]        wr_tag;
  logic                    wr_dirty;
  logic [BLOCK_ADDR_W-1:0] miss_block;
  logic [LINE_W-1:0]       fetch_buf;
  logic                    unused_addr_bits;

  assign offset           = address[3:2];
  assign index            = address[6:4];
  assign tag              = address[31:7];
  assign unused_addr_bits = ^address[1:0];
  assign request          = read | write;

  // Outside IDLE the store is looked up at the miss index so the victim
  // stays addressable even if the CPU drops or changes its request.
  assign store_index = (state == ST_IDLE) ? index : miss_block[INDEX_W-1:0];

  cache_line_store u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_index (store_index),
    .rd_data  (line_data),
    .rd_tag   (line_tag),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_data  (wr_data),
    .wr_tag   (wr_tag),
    .wr_dirty (wr_dirty)
  );

  assign hit      = line_valid && (line_tag == tag);
  assign busywait = request && !((state == ST_IDLE) && hit);

  // Word select for loads; only meaningful when busywait is low.
  always_comb begin
    readdata = line_data[WORD_W-1:0];
    case (offset)
      2'd0:    readdata = line_data[0*WORD_W +: WORD_W];
      2'd1:    readdata = line_data[1*WORD_W +: WORD_W];
      2'd2:    readdata = line_data[2*WORD_W +: WORD_W];
      default: readdata = line_data[3*WORD_W +: WORD_W];
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latch the missing block address so a dropped request still completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_block <= '0;
    end else if ((state == ST_IDLE) && request && !hit) begin
      miss_block <= address[31:4];
    end
  end

  // Capture the fetched block on the completing edge of ALLOCATE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_buf <= '0;
    end else if ((state == ST_ALLOCATE) && !mem_busywait) begin
      fetch_buf <= mem_readdata;
    end
  end

  // Next-state logic, memory handshake and store write port.
  always_comb begin
    next_state    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    wr_en         = 1'b0;
    wr_index      = index;
    wr_data       = merge_word(line_data, offset, writedata);
    wr_tag        = tag;
    wr_dirty      = 1'b1;
    case (state)
      ST_IDLE: begin
        if (request && !hit) begin
          next_state = (line_valid && line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        end else if (write && hit) begin
          wr_en = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {line_tag, miss_block[INDEX_W-1:0]};
        mem_writedata = line_data;
        if (!mem_busywait) begin
          next_state = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = miss_block;
        if (!mem_busywait) begin
          next_state = ST_UPDATE;
        end
      end
      default: begin
        wr_en      = 1'b1;
        wr_index   = miss_block[INDEX_W-1:0];
        wr_data    = fetch_buf;
        wr_tag     = miss_block[BLOCK_ADDR_W-1:INDEX_W];
        wr_dirty   = 1'b0;
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache_controller
// Brief    : Scoreboard bench. CPU-side expectations come from a flat word
//            memory plus a line-occupancy model; a memory responder checks
//            block traffic against the same reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache_controller;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b0;

  always #5 clk = ~clk;

  data_cache_controller dut (
    .clk           (clk),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  typedef struct { bit is_write; logic [31:0] data; int stall; } exp_t;
  typedef struct { bit is_wb; logic [27:0] addr; } mexp_t;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];
  mexp_t       mq[$];
  bit          mv[8];
  logic [24:0] mt[8];
  bit          md[8];
  logic [31:0] ref_mem[int unsigned];
  logic [31:0] backing[int unsigned];
  int          wb_wait = 0;
  int          alloc_wait = 0;
  int          mon_stall = 0;
  exp_t        mon_e;
  int          wcnt = 0;
  mexp_t       me;
  logic [127:0] blk;

  function automatic logic [31:0] init_word(int unsigned wa);
    return 32'(32'h5A00_0000 ^ (wa * 32'h9E37_79B1));
  endfunction

  function automatic logic [31:0] ref_word(int unsigned wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [31:0] backing_word(int unsigned wa);
    if (backing.exists(wa)) return backing[wa];
    return init_word(wa);
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // After reset dirty lines are lost, so the reference reverts to memory.
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    ref_mem = backing;
    sb.delete();
    mq.delete();
  endtask

  // Cache occupancy model: decides hit / clean miss / dirty miss and the
  // block traffic and stall cycles each implies.
  task automatic predict(bit wr, logic [31:0] addr, logic [31:0] wdata,
                         int ww, int aw, output int stall);
    int unsigned idx;
    logic [24:0] tg;
    idx   = int'(addr[6:4]);
    tg    = addr[31:7];
    stall = 0;
    if (!(mv[idx] && mt[idx] == tg)) begin
      stall = 3 + aw;
      if (mv[idx] && md[idx]) begin
        stall += 1 + ww;
        mq.push_back('{1'b1, {mt[idx], addr[6:4]}});
      end
      mq.push_back('{1'b0, addr[31:4]});
      mv[idx] = 1'b1;
      mt[idx] = tg;
      md[idx] = 1'b0;
    end
    if (wr) begin
      ref_mem[int'(addr[31:2])] = wdata;
      md[idx] = 1'b1;
    end
  endtask

  // Issue one CPU request, hold it until busywait falls, then release.
  task automatic do_txn(bit rd, bit wr, logic [31:0] addr, logic [31:0] wdata,
                        int ww, int aw);
    int stall;
    bit done;
    predict(wr, addr, wdata, ww, aw, stall);
    sb.push_back('{wr, ref_word(int'(addr[31:2])), stall});
    wb_wait    = ww;
    alloc_wait = aw;
    read       = rd;
    write      = wr;
    address    = addr;
    writedata  = wdata;
    done       = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!busywait) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL txn_timeout: busywait still high for addr %0h", addr);
    end
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic wait_mem_read(string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_read) seen = 1'b1;
    end
    check(name, 128'(seen), 128'd1);
  endtask

  // CPU-side monitor: counts stall cycles and checks each completed request.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_read && mem_write) begin
        vectors++;
        miscompares++;
        $display("FAIL mem_exclusive: mem_read and mem_write both 1 at %0t", $time);
      end
      if (!reset || !(read || write)) begin
        mon_stall = 0;
      end else if (busywait) begin
        mon_stall++;
      end else begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_empty: request completed with nothing expected");
        end else begin
          mon_e = sb.pop_front();
          check("stall_cycles", 128'(mon_stall), 128'(mon_e.stall));
          if (!mon_e.is_write) check("readdata", 128'(readdata), 128'(mon_e.data));
        end
        mon_stall = 0;
      end
    end
  end

  // Main-memory responder with programmable wait states.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && (mem_read || mem_write)) begin
        if (wcnt < (mem_write ? wb_wait : alloc_wait)) begin
          mem_busywait = 1'b1;
          wcnt++;
        end else begin
          mem_busywait = 1'b0;
          wcnt = 0;
          if (mq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL mem_unexpected: op with addr %0h", mem_address);
          end else begin
            me = mq.pop_front();
            check("mem_op_is_write", 128'(mem_write), 128'(me.is_wb));
            check("mem_address", 128'(mem_address), 128'(me.addr));
          end
          for (int w = 0; w < 4; w++) begin
            if (mem_write) blk[w*32 +: 32] = ref_word(int'({mem_address, 2'(w)}));
            else           blk[w*32 +: 32] = backing_word(int'({mem_address, 2'(w)}));
          end
          if (mem_write) begin
            check("mem_writedata", mem_writedata, blk);
            for (int w = 0; w < 4; w++) backing[int'({mem_address, 2'(w)})] = blk[w*32 +: 32];
          end else begin
            mem_readdata = blk;
          end
        end
      end else begin
        mem_busywait = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int kind;
    // Reset state, with and without a pending request.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busywait_idle", 128'(busywait), 128'd0);
    check("rst_mem_read", 128'(mem_read), 128'd0);
    check("rst_mem_write", 128'(mem_write), 128'd0);
    check("rst_mem_address", 128'(mem_address), 128'd0);
    check("rst_mem_writedata", mem_writedata, 128'd0);
    read = 1'b1;
    address = 32'h40;
    #1;
    check("rst_busywait_req", 128'(busywait), 128'd1);
    read = 1'b0;

    backing[32'h10] = 32'h41;
    backing[32'h11] = 32'h42;
    backing[32'h12] = 32'h43;
    backing[32'h13] = 32'h44;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // First load miss with two memory wait cycles.
    do_txn(1, 0, 32'h0000_0040, 32'h0, 0, 2);

    // Reset in the middle of ALLOCATE.
    mq.push_back('{1'b0, 28'h5});
    alloc_wait = 8;
    read = 1'b1;
    address = 32'h0000_0050;
    wait_mem_read("abort_saw_mem_read");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_mem_read", 128'(mem_read), 128'd0);
    check("abort_mem_address", 128'(mem_address), 128'd0);
    check("abort_busywait", 128'(busywait), 128'd1);
    read = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_txn(1, 0, 32'h0000_0050, 32'h0, 0, 0);
    do_txn(1, 0, 32'h0000_0040, 32'h0, 1, 1);

    // Read+write together on a hit acts as a write.
    do_txn(1, 1, 32'h0000_0040, 32'h1234_5678, 0, 0);
    do_txn(1, 0, 32'h0000_0040, 32'h0, 0, 0);

    // Store hit, load hit, then conflicting load forces write-back.
    do_txn(0, 1, 32'h0000_0048, 32'hDEAD_BEEF, 0, 0);
    do_txn(1, 0, 32'h0000_0048, 32'h0, 0, 0);
    do_txn(1, 0, 32'h0000_00C8, 32'h0, 1, 1);

    // Store miss dropped during ALLOCATE: line fills clean, no store.
    mq.push_back('{1'b0, 28'h7});
    alloc_wait = 2;
    write = 1'b1;
    writedata = 32'hCAFE_F00D;
    address = 32'h0000_0074;
    wait_mem_read("drop_saw_mem_read");
    @(posedge clk);
    #1;
    write = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    mv[7] = 1'b1;
    mt[7] = '0;
    md[7] = 1'b0;
    do_txn(1, 0, 32'h0000_0074, 32'h0, 0, 0);

    // Zero-wait clean miss, dirtying store, then dirty miss.
    do_txn(1, 0, 32'h0000_0160, 32'h0, 0, 0);
    do_txn(0, 1, 32'h0000_0164, 32'h0BAD_F00D, 0, 0);
    do_txn(1, 0, 32'h0000_01E0, 32'h0, 0, 0);

    // Randomized traffic over four tags per index.
    repeat (150) begin
      a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      kind = int'($urandom_range(0, 2));
      do_txn(kind != 1, kind != 0, a, $urandom,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    repeat (5) @(posedge clk);
    check("sb_drained", 128'(sb.size()), 128'd0);
    check("mq_drained", 128'(mq.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_cache_controller.md
DATA_CACHE_CONTROLLER -- requirements
Module: data_cache_controller

Interface
REQ-001 SHALL have no parameters; geometry fixed: 8 lines, direct-mapped, 4 words/line, write-back, write-allocate.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 read  in  1  CPU load request, held until busywait low.
REQ-005 write  in  1  CPU store request, held until busywait low.
REQ-006 address  in  32  CPU byte address; [1:0] ignored, [3:2] word offset, [6:4] index, [31:7] tag.
REQ-007 writedata  in  32  store data.
REQ-008 readdata  out  32  load data.
REQ-009 busywait  out  1  stall to CPU pipeline.
REQ-010 mem_read  out  1  block fetch request to main memory.
REQ-011 mem_write  out  1  block write-back request to main memory.
REQ-012 mem_address  out  28  block address (byte address [31:4]).
REQ-013 mem_writedata  out  128  victim block; word 0 in [31:0].
REQ-014 mem_readdata  in  128  fetched block; word 0 in [31:0].
REQ-015 mem_busywait  in  1  memory busy; transfer completes on first edge with mem_busywait low while request high.

Function
REQ-016 Hit = valid[index] and tag[index]==address[31:7]; evaluated combinationally.
REQ-017 busywait SHALL equal (read|write) and not (state==IDLE and hit); no stall on hit.
REQ-018 Read hit: readdata = selected word, same cycle, no state change.
REQ-019 Write hit: word written and dirty[index] set on next rising edge; other words unchanged.
REQ-020 read and write both high: treated as write.
REQ-021 FSM states IDLE, WRITEBACK, ALLOCATE, UPDATE.
REQ-022 IDLE: miss with valid and dirty victim -> WRITEBACK; miss otherwise -> ALLOCATE; else stay.
REQ-023 WRITEBACK: mem_write=1, mem_address={victim tag,index}, mem_writedata=victim block; exit to ALLOCATE on edge with mem_busywait low.
REQ-024 ALLOCATE: mem_read=1, mem_address=address[31:4]; exit to UPDATE on edge with mem_busywait low, capturing mem_readdata.
REQ-025 UPDATE: one cycle; line written with fetched block, tag set, valid=1, dirty=0; -> IDLE, where held request hits.
REQ-026 mem_read and mem_write never high together; both low in IDLE and UPDATE.
REQ-027 Miss penalty with zero-wait memory: clean miss 3 stall cycles, dirty miss 4.
REQ-028 Request dropped mid-miss: FSM completes the sequence, no CPU-side write performed.
REQ-029 readdata in non-hit cycles: don't-care; verification SHALL check it only when busywait low.

Reset
REQ-030 reset low: state=IDLE, all valid and dirty bits 0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, immediately and asynchronously.
REQ-031 Reset mid-WRITEBACK/ALLOCATE aborts transfer; data array contents undefined, tags need no reset.
REQ-032 busywait after reset: follows REQ-017 (all requests miss).

Structure
REQ-033 Shared package holds line/word/index/tag width constants and FSM state enumeration.
REQ-034 Single sub-module cache_line_store (data/tag/valid/dirty arrays, one write port, combinational read) is natural; FSM stays in top.

Verification
REQ-035 Reset, read 0x0000_0040, memory returns block {0x44,0x43,0x42,0x41} after 2 wait cycles -> mem_read with mem_address 0x0000004, busywait released, readdata 0x41.
REQ-036 Write 0xDEADBEEF to 0x0000_0048 then read it -> both hit with no stall, readdata 0xDEADBEEF, dirty[4] set.
REQ-037 After REQ-036, read 0x0000_00C8 (same index, new tag) -> mem_write first, mem_address 0x0000004, mem_writedata word 2 = 0xDEADBEEF, then mem_read, mem_address 0x000000C.
REQ-038 read and write both high on hit at 0x0000_0040, writedata 0x12345678 -> treated as write, subsequent read returns 0x12345678.
REQ-039 Assert reset during ALLOCATE -> mem_read falls immediately, state IDLE, next read of same address misses again.
REQ-040 Zero-wait memory, clean miss then dirty miss -> busywait high exactly 3 and 4 cycles respectively.
